// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// The result register holds between conversions so the display path always sees a stable value.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_overflow
);

    localparam int BCD_W              = 4 * DIGITS;
    localparam int ITER_W             = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL   = 10 ** DIGITS - 1;
    localparam logic [ITER_W-1:0] ITER_INIT = ITER_W'(BIN_W);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   scratch_next;
    logic [BIN_W-1:0]   shift;
    logic [BIN_W-1:0]   shift_next;
    logic [ITER_W-1:0]  iter;
    logic               ovf_q;
    logic               in_overflow;

    assign in_overflow = 32'(i_bin) > MAX_VAL;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift the
    // whole {scratch, shift} pair left; the bit leaving the top is discarded.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves it unassigned and no latch is inferred.
        adjusted = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        {scratch_next, shift_next} = {adjusted, shift} << 1;
    end

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            scratch    <= '0;
            shift      <= '0;
            iter       <= '0;
            ovf_q      <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_bcd      <= '0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        shift   <= i_bin;
                        scratch <= '0;
                        iter    <= ITER_INIT;
                        ovf_q   <= in_overflow;
                        o_busy  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    shift   <= shift_next;
                    iter    <= iter - 1'b1;
                    if (iter == ITER_LAST) begin
                        state      <= IDLE;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        o_bcd      <= ovf_q ? {DIGITS{4'h9}} : scratch_next;
                        o_overflow <= ovf_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level decimal model.
module tb_bin_to_bcd_seq;

    localparam int BIN_W   = 14;
    localparam int MAX_VAL = 9999;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_start = 1'b0;
    logic [BIN_W-1:0]  i_bin = '0;
    logic              o_busy;
    logic              o_done;
    logic [15:0]       o_bcd;
    logic              o_overflow;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_bin      (i_bin),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bcd      (o_bcd),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Decimal reference: digits by division, saturated to 9999 when out of range.
    function automatic logic [15:0] ref_bcd(input int v);
        if (v > MAX_VAL) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Transaction model: an accepted start schedules a result BIN_W edges later.
    int          m_remaining = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_bcd = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_pend_bcd = '0;
    logic        m_pend_ovf = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_remaining = 0;
            m_done      = 1'b0;
            m_bcd       = '0;
            m_ovf       = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_remaining > 0) begin
                m_remaining--;
                if (m_remaining == 0) begin
                    m_done = 1'b1;
                    m_bcd  = m_pend_bcd;
                    m_ovf  = m_pend_ovf;
                end
            end else if (i_start) begin
                m_pend_bcd  = ref_bcd(int'(i_bin));
                m_pend_ovf  = int'(i_bin) > MAX_VAL;
                m_remaining = BIN_W;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 32'(o_busy), 32'(m_remaining > 0));
            check("done", 32'(o_done), 32'(m_done));
            check("bcd", 32'(o_bcd), 32'(m_bcd));
            check("overflow", 32'(o_overflow), 32'(m_ovf));
        end
    end

    task automatic convert(input int v, input logic [15:0] exp_bcd, input logic exp_ovf, input string tag);
        int lat;
        @(negedge clk);
        i_start = 1'b1;
        i_bin   = BIN_W'(v);
        @(negedge clk);
        i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd15);
        check({tag, "_bcd"}, 32'(o_bcd), 32'(exp_bcd));
        check({tag, "_ovf"}, 32'(o_overflow), 32'(exp_ovf));
    endtask

    initial begin
        int dones;
        int prev;
        logic [15:0] seen_bcd;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_bcd", 32'(o_bcd), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        convert(0,     16'h0000, 1'b0, "zero");
        convert(6000,  16'h6000, 1'b0, "v6000");
        convert(1234,  16'h1234, 1'b0, "v1234");
        convert(9999,  16'h9999, 1'b0, "v9999");
        convert(10000, 16'h9999, 1'b1, "v10000");
        convert(11600, 16'h9999, 1'b1, "v11600");
        convert(5,     16'h0005, 1'b0, "v5");

        // Start ignored while busy: only the first value converts.
        @(negedge clk);
        i_start = 1'b1;
        i_bin   = BIN_W'(42);
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        i_start = 1'b1;
        i_bin   = BIN_W'(77);
        @(negedge clk);
        i_start = 1'b0;
        dones = 0;
        seen_bcd = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (o_done) begin
                dones++;
                seen_bcd = o_bcd;
            end
        end
        check("ignore_dones", 32'(dones), 32'd1);
        check("ignore_bcd", 32'(seen_bcd), 32'h0042);

        // Start held high: one conversion every BIN_W+1 cycles.
        prev = -1;
        i_start = 1'b1;
        for (int k = 0; k <= 200; k++) begin
            @(negedge clk);
            if (o_done) begin
                if (prev >= 0) check("b2b_period", 32'(k - prev), 32'd15);
                prev = k;
            end
            i_bin = BIN_W'(k);
        end
        @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(negedge clk);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        i_start = 1'b1;
        i_bin   = BIN_W'(1234);
        @(negedge clk);
        i_start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_bcd", 32'(o_bcd), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        convert(4321, 16'h4321, 1'b0, "after_abort");

        // Random traffic, including starts while busy and values around the limit.
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            i_start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       i_bin = BIN_W'($urandom_range(0, 16383));
                1:       i_bin = BIN_W'($urandom_range(9990, 10010));
                2:       i_bin = BIN_W'($urandom_range(0, 9999));
                default: i_bin = BIN_W'($urandom_range(0, 20));
            endcase
        end
        @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(negedge clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
